// File: rtl/raytracing_result_collector.sv
// Snapshots a batch of worker colour buffers and streams its pixels to the framebuffer in ascending x.
// First write 2 cycles after accept; stalls on fb_ready, clipped pixels skip it. RESULT_COLLECTOR_PINGPONG_EN adds a second bank.
module raytracing_result_collector #(
  parameter int N_WORKERS        = 4,
  parameter int JOBS_SUBDIVISION = 8,
  parameter int COLOR_B          = 12,
  parameter int H_RES            = 640,
  parameter int V_RES            = 480,
  parameter int ADDR_B           = 19
) (
  input  logic                                          clk,
  input  logic                                          rst_,
  input  logic                                          batch_valid,
  output logic                                          batch_ready,
  input  logic [9:0]                                    batch_x,
  input  logic [8:0]                                    batch_y,
  input  logic [N_WORKERS*JOBS_SUBDIVISION*COLOR_B-1:0] worker_buffers,
  output logic                                          fb_we,
  output logic [ADDR_B-1:0]                             fb_addr,
  output logic [COLOR_B-1:0]                            fb_data,
  input  logic                                          fb_ready,
  output logic                                          frame_done
);

`ifdef RESULT_COLLECTOR_PINGPONG_EN
  localparam logic PP = 1'b1;
`else
  localparam logic PP = 1'b0;
`endif

  localparam int NPIX = N_WORKERS * JOBS_SUBDIVISION;
  localparam int IW   = (NPIX > 1) ? $clog2(NPIX) : 1;
  localparam int PW   = NPIX * COLOR_B;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] LOAD  = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  logic [1:0]        state_q, state_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [ADDR_B-1:0] base_q, base_d;
  logic              hit_q, hit_d;
  logic              yclip_q, yclip_d;
  logic [1:0]        full_q, full_d;
  logic              wr_q, wr_d;
  logic              rd_q, rd_d;

  logic [PW-1:0]     snap_dat_q [2];
  logic [9:0]        snap_x_q   [2];
  logic [8:0]        snap_y_q   [2];

  logic              accept;
  logic              draining;
  logic              clip;
  logic              adv;
  logic              last;
  logic [31:0]       pix_x;
  logic [IW-1:0]     sel;

  // Without ping-pong the pointers never move, so bank 1 is never written.
  assign batch_ready = !full_q[wr_q];
  assign accept      = batch_valid && batch_ready;
  assign draining    = (state_q == DRAIN);
  assign pix_x       = 32'(snap_x_q[rd_q]) + 32'(idx_q);
  assign clip        = yclip_q || (pix_x >= 32'(H_RES));
  assign adv         = draining && (clip || fb_ready);
  assign last        = (idx_q == IW'(NPIX - 1));
  assign sel         = IW'((32'(idx_q) % N_WORKERS) * JOBS_SUBDIVISION + 32'(idx_q) / N_WORKERS);

  assign fb_we      = draining && !clip;
  assign fb_addr    = draining ? (base_q + ADDR_B'(idx_q)) : '0;
  assign fb_data    = draining ? snap_dat_q[rd_q][int'(sel)*COLOR_B +: COLOR_B] : '0;
  assign frame_done = (state_q == DONE) && hit_q;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    base_d  = base_q;
    hit_d   = hit_q;
    yclip_d = yclip_q;
    full_d  = full_q;
    wr_d    = wr_q;
    rd_d    = rd_q;
    if (accept) begin
      full_d[wr_q] = 1'b1;
      wr_d         = wr_q ^ PP;
    end
    case (state_q)
      IDLE: if (accept) state_d = LOAD;
      LOAD: begin
        base_d  = ADDR_B'(32'(snap_y_q[rd_q]) * 32'(H_RES) + 32'(snap_x_q[rd_q]));
        yclip_d = 32'(snap_y_q[rd_q]) >= 32'(V_RES);
        hit_d   = (32'(snap_y_q[rd_q]) == 32'(V_RES - 1)) &&
                  (32'(snap_x_q[rd_q]) <= 32'(H_RES - 1)) &&
                  (32'(snap_x_q[rd_q]) + 32'(NPIX - 1) >= 32'(H_RES - 1));
        idx_d   = '0;
        state_d = DRAIN;
      end
      DRAIN: if (adv) begin
        idx_d = idx_q + 1'b1;
        if (last) state_d = DONE;
      end
      default: begin
        full_d[rd_q] = 1'b0;
        rd_d         = rd_q ^ PP;
        // A batch waiting in (or entering) the other bank starts immediately.
        state_d = (PP && (full_q[~rd_q] || accept)) ? LOAD : IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      state_q <= IDLE;
      idx_q   <= '0;
      base_q  <= '0;
      hit_q   <= 1'b0;
      yclip_q <= 1'b0;
      full_q  <= '0;
      wr_q    <= 1'b0;
      rd_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      base_q  <= base_d;
      hit_q   <= hit_d;
      yclip_q <= yclip_d;
      full_q  <= full_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      snap_dat_q[wr_q] <= worker_buffers;
      snap_x_q[wr_q]   <= batch_x;
      snap_y_q[wr_q]   <= batch_y;
    end
  end

endmodule

// File: tb/tb_raytracing_result_collector.sv
// Randomized bench for raytracing_result_collector against a queue-based pixel model.
module tb_raytracing_result_collector;

  localparam int NW = 4, NJ = 8, CB = 12, HR = 640, VR = 480, AB = 19;
  localparam int NPIX = NW * NJ;
  localparam int PW = NPIX * CB;
`ifdef RESULT_COLLECTOR_PINGPONG_EN
  localparam logic PP = 1'b1;
`else
  localparam logic PP = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_ = 1'b0;
  logic          batch_valid = 1'b0;
  logic          batch_ready;
  logic [9:0]    batch_x = '0;
  logic [8:0]    batch_y = '0;
  logic [PW-1:0] worker_buffers = '0;
  logic          fb_we;
  logic [AB-1:0] fb_addr;
  logic [CB-1:0] fb_data;
  logic          fb_ready = 1'b1;
  logic          frame_done;

  raytracing_result_collector #(
    .N_WORKERS(NW), .JOBS_SUBDIVISION(NJ), .COLOR_B(CB),
    .H_RES(HR), .V_RES(VR), .ADDR_B(AB)
  ) dut (
    .clk(clk), .rst_(rst_), .batch_valid(batch_valid), .batch_ready(batch_ready),
    .batch_x(batch_x), .batch_y(batch_y), .worker_buffers(worker_buffers),
    .fb_we(fb_we), .fb_addr(fb_addr), .fb_data(fb_data), .fb_ready(fb_ready),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AB-1:0] addr;
    logic [CB-1:0] dat;
  } wr_t;

  wr_t           exp_q[$];
  int            wr_cyc[$];
  wr_t           mon_e;
  int            vec_cnt = 0, err_cnt = 0;
  int            fd_cnt = 0, exp_fd = 0, wr_cnt = 0, ncyc = 0;
  int            rdy_mode = 0, rdy_ph = 0;
  logic [AB-1:0] first_addr = '0, last_addr = '0, prev_addr = '0;
  logic [CB-1:0] prev_dat = '0;
  logic          prev_stall = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: every pixel of the batch, in x order, minus the off-screen ones.
  task automatic model_push(input logic [9:0] bx, input logic [8:0] by, input logic [PW-1:0] b);
    wr_t e;
    for (int i = 0; i < NPIX; i++) begin
      int x, w, j;
      x = int'(bx) + i;
      w = i % NW;
      j = i / NW;
      if (x < HR && int'(by) < VR) begin
        e.addr = AB'(int'(by) * HR + x);
        e.dat  = b[(w*NJ + j)*CB +: CB];
        exp_q.push_back(e);
      end
      if (x == HR - 1 && int'(by) == VR - 1) exp_fd++;
    end
  endtask

  always @(negedge clk) begin
    ncyc++;
    if (rst_) begin
      if (prev_stall) begin
        check("stall_we", 32'(fb_we), 32'd1);
        check("stall_addr", 32'(fb_addr), 32'(prev_addr));
        check("stall_dat", 32'(fb_data), 32'(prev_dat));
      end
      if (fb_we && fb_ready) begin
        if (exp_q.size() == 0) begin
          check("extra_write_addr", 32'(fb_addr), 32'hFFFF_FFFF);
        end else begin
          mon_e = exp_q.pop_front();
          check("wr_addr", 32'(fb_addr), 32'(mon_e.addr));
          check("wr_dat", 32'(fb_data), 32'(mon_e.dat));
        end
        if (wr_cnt == 0) first_addr = fb_addr;
        last_addr = fb_addr;
        wr_cnt++;
        wr_cyc.push_back(ncyc);
      end
      if (frame_done) fd_cnt++;
    end
    prev_stall = rst_ && fb_we && !fb_ready;
    prev_addr  = fb_addr;
    prev_dat   = fb_data;
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      rdy_ph++;
      case (rdy_mode)
        1:       fb_ready = (rdy_ph % 4 == 0) || (rdy_ph % 4 == 3);
        2:       fb_ready = 1'($urandom_range(0, 1));
        default: fb_ready = 1'b1;
      endcase
    end
  end

  task automatic send_batch(input logic [9:0] bx, input logic [8:0] by, input logic [PW-1:0] b,
                            output int tries);
    @(posedge clk);
    #1;
    batch_x = bx;
    batch_y = by;
    worker_buffers = b;
    batch_valid = 1'b1;
    for (tries = 1; tries <= 300; tries++) begin
      @(negedge clk);
      if (batch_ready) break;
    end
    if (tries > 300) begin
      check("accept_timeout", 32'(tries), 32'd0);
    end else begin
      @(posedge clk);
      model_push(bx, by, b);
    end
    #1;
    batch_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    for (n = 0; n < 3000; n++) begin
      @(posedge clk);
      if (exp_q.size() == 0) break;
    end
    if (n >= 3000) check("drain_timeout", 32'(exp_q.size()), 32'd0);
    repeat (NPIX + 4) @(posedge clk);
  endtask

  function automatic logic [PW-1:0] rand_buf();
    logic [PW-1:0] b;
    for (int k = 0; k < NPIX; k++) b[k*CB +: CB] = CB'($urandom);
    return b;
  endfunction

  initial begin
    logic [PW-1:0] b;
    logic [11:0]   pat;
    int            tries, fd0;
    logic [9:0]    bx;
    logic [8:0]    by;

    #3;
    check("rst_rdy", 32'(batch_ready), 32'd1);
    check("rst_we", 32'(fb_we), 32'd0);
    check("rst_addr", 32'(fb_addr), 32'd0);
    check("rst_dat", 32'(fb_data), 32'd0);
    check("rst_fd", 32'(frame_done), 32'd0);
    #19;
    rst_ = 1'b1;

    // Patterned batch at the origin: cycle-exact timing.
    for (int w = 0; w < NW; w++)
      for (int j = 0; j < NJ; j++)
        b[(w*NJ + j)*CB +: CB] = {4'(w), 4'(j), 4'hA};
    send_batch(10'd0, 9'd0, b, tries);
    @(negedge clk);
    check("t1_load_we", 32'(fb_we), 32'd0);
    check("t1_load_rdy", 32'(batch_ready), 32'(PP));
    for (int i = 0; i < NPIX; i++) begin
      @(negedge clk);
      pat = {4'(i % 4), 4'(i / 4), 4'hA};
      check("t1_we", 32'(fb_we), 32'd1);
      check("t1_addr", 32'(fb_addr), 32'(i));
      check("t1_dat", 32'(fb_data), 32'(pat));
    end
    @(negedge clk);
    check("t1_done_we", 32'(fb_we), 32'd0);
    check("t1_done_rdy", 32'(batch_ready), 32'(PP));
    @(negedge clk);
    check("t1_idle_rdy", 32'(batch_ready), 32'd1);
    wait_drain();

    wr_cnt = 0;
    send_batch(10'd64, 9'd2, rand_buf(), tries);
    wait_drain();
    check("t2_first", 32'(first_addr), 32'd1344);
    check("t2_last", 32'(last_addr), 32'd1375);
    check("t2_cnt", 32'(wr_cnt), 32'd32);

    rdy_mode = 1;
    wr_cnt = 0;
    send_batch(10'($urandom_range(0, 600)), 9'($urandom_range(0, 479)), rand_buf(), tries);
    wait_drain();
    check("t3_cnt", 32'(wr_cnt), 32'd32);
    rdy_mode = 0;

    wr_cnt = 0;
    fd0 = fd_cnt;
    send_batch(10'd624, 9'd479, rand_buf(), tries);
    wait_drain();
    check("t4_cnt", 32'(wr_cnt), 32'd16);
    check("t4_first", 32'(first_addr), 32'd307184);
    check("t4_last", 32'(last_addr), 32'd307199);
    check("t4_fd", 32'(fd_cnt - fd0), 32'd1);

    wr_cnt = 0;
    fd0 = fd_cnt;
    send_batch(10'd0, 9'd480, rand_buf(), tries);
    wait_drain();
    check("t5_cnt", 32'(wr_cnt), 32'd0);
    check("t5_fd", 32'(fd_cnt - fd0), 32'd0);

    // Asynchronous reset while pixel 10 is on the port.
    wr_cnt = 0;
    send_batch(10'd100, 9'd10, rand_buf(), tries);
    for (int n = 0; n < 200; n++) begin
      @(posedge clk);
      if (wr_cnt >= 10) break;
    end
    check("t6_reached10", 32'(wr_cnt), 32'd10);
    #2;
    rst_ = 1'b0;
    #1;
    check("t6_rst_we", 32'(fb_we), 32'd0);
    check("t6_rst_rdy", 32'(batch_ready), 32'd1);
    check("t6_rst_addr", 32'(fb_addr), 32'd0);
    exp_q.delete();
    @(negedge clk);
    @(posedge clk);
    #3;
    rst_ = 1'b1;
    check("t6_post_rdy", 32'(batch_ready), 32'd1);
    wr_cnt = 0;
    send_batch(10'd0, 9'd100, rand_buf(), tries);
    wait_drain();
    check("t6_cnt", 32'(wr_cnt), 32'd32);

`ifdef RESULT_COLLECTOR_PINGPONG_EN
    wr_cnt = 0;
    wr_cyc.delete();
    send_batch(10'd0, 9'd200, rand_buf(), tries);
    repeat (5) @(negedge clk);
    check("pp_rdy_drain", 32'(batch_ready), 32'd1);
    send_batch(10'd32, 9'd200, rand_buf(), tries);
    check("pp_tries", 32'(tries), 32'd1);
    wait_drain();
    check("pp_cnt", 32'(wr_cnt), 32'd64);
    if (wr_cyc.size() >= 33) check("pp_gap", 32'(wr_cyc[32] - wr_cyc[31]), 32'd3);
    else check("pp_gap_missing", 32'(wr_cyc.size()), 32'd64);
`endif

    for (int it = 0; it < 20; it++) begin
      rdy_mode = $urandom_range(0, 2);
      bx = 10'($urandom_range(0, 700));
      by = 9'($urandom_range(0, 485));
      if (it % 5 == 4) begin
        by = 9'd479;
        bx = 10'($urandom_range(610, 639));
      end
      send_batch(bx, by, rand_buf(), tries);
    end
    wait_drain();
    rdy_mode = 0;
    check("fd_total", 32'(fd_cnt), 32'(exp_fd));
    check("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got %0d miscompares so far expected completion", err_cnt);
    $fatal(1);
  end

endmodule
